// File: rtl/mc_controller.sv
// mc_controller: multi-cycle main control FSM (FETCH/DECODE/EXE/MEM/WB/HALT).
// Drives ALUOp, all datapath write enables and mux selects, one stage per cycle,
// waits on mem_ready in MEM, pulses instr_done on retirement and counts retired
// instructions modulo 2^CNT_W.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown encodings in
// HALT with a sticky illegal flag; otherwise unknown encodings retire as nop.
module mc_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [2:0]       state,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       ALUOp,
   output logic             ALUSrcB,
   output logic             EXTOp,
   output logic [1:0]       RegDst,
   output logic [1:0]       WDSel,
   output logic [1:0]       NPCOp,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_cnt,
   output logic             illegal
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_OR  = 4'd2;
   localparam logic [3:0] ALU_LUI = 4'd3;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instr_cnt_q;

   logic       pcw_s, irw_s, rw_s, mw_s, done_s;
   logic [3:0] aluop_s;
   logic       srcb_s, ext_s;
   logic [1:0] rdst_s, wd_s, npc_s;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic       trap_s;
   logic       illegal_q;
`endif

   // Instruction decode (opcode/funct are stable from DECODE onwards)
   logic is_rtype_s, is_addu_s, is_subu_s, is_jr_s, is_nop_s;
   logic is_ori_s, is_lui_s, is_lw_s, is_sw_s, is_beq_s, is_jal_s;

   assign is_rtype_s = (opcode == 6'b000000);
   assign is_addu_s  = is_rtype_s && (funct == 6'b100001);
   assign is_subu_s  = is_rtype_s && (funct == 6'b100011);
   assign is_jr_s    = is_rtype_s && (funct == 6'b001000);
   assign is_nop_s   = is_rtype_s && (funct == 6'b000000);
   assign is_ori_s   = (opcode == 6'b001101);
   assign is_lui_s   = (opcode == 6'b001111);
   assign is_lw_s    = (opcode == 6'b100011);
   assign is_sw_s    = (opcode == 6'b101011);
   assign is_beq_s   = (opcode == 6'b000100);
   assign is_jal_s   = (opcode == 6'b000011);

   // Next-state, retirement and Moore control decode for the current stage
   always_comb begin
      state_d = state_q;
      done_s  = 1'b0;
      pcw_s   = 1'b0;
      irw_s   = 1'b0;
      rw_s    = 1'b0;
      mw_s    = 1'b0;
      aluop_s = ALU_ADD;
      srcb_s  = 1'b0;
      ext_s   = 1'b0;
      rdst_s  = 2'd0;
      wd_s    = 2'd0;
      npc_s   = 2'd0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      trap_s  = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            irw_s   = 1'b1;
            pcw_s   = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_addu_s || is_subu_s || is_jr_s || is_ori_s || is_lui_s ||
                is_lw_s || is_sw_s || is_beq_s) begin
               state_d = S_EXE;
            end else if (is_jal_s) begin
               state_d = S_WB;
            end else if (is_nop_s) begin
               state_d = S_FETCH;
               done_s  = 1'b1;
            end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               state_d = S_HALT;
               trap_s  = 1'b1;
`else
               state_d = S_FETCH;
               done_s  = 1'b1;
`endif
            end
         end
         S_EXE: begin
            if (is_addu_s) begin
               aluop_s = ALU_ADD;
            end else if (is_subu_s) begin
               aluop_s = ALU_SUB;
            end else if (is_beq_s) begin
               aluop_s = ALU_SUB;
               pcw_s   = zero;
               npc_s   = 2'd1;
            end else if (is_ori_s) begin
               aluop_s = ALU_OR;
               srcb_s  = 1'b1;
               ext_s   = 1'b0;
            end else if (is_lui_s) begin
               aluop_s = ALU_LUI;
               srcb_s  = 1'b1;
            end else if (is_lw_s || is_sw_s) begin
               aluop_s = ALU_ADD;
               srcb_s  = 1'b1;
               ext_s   = 1'b1;
            end else if (is_jr_s) begin
               pcw_s   = 1'b1;
               npc_s   = 2'd3;
            end else begin
               aluop_s = ALU_ADD;
            end
            if (is_lw_s || is_sw_s) begin
               state_d = S_MEM;
            end else if (is_beq_s || is_jr_s) begin
               state_d = S_FETCH;
               done_s  = 1'b1;
            end else if (is_addu_s || is_subu_s || is_ori_s || is_lui_s) begin
               state_d = S_WB;
            end else begin
               // Unreachable with a stable IR: recover without retiring
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            // Address computation stays on the ALU while memory completes
            aluop_s = ALU_ADD;
            srcb_s  = 1'b1;
            ext_s   = 1'b1;
            if (is_sw_s) begin
               mw_s = 1'b1;
               if (mem_ready) begin
                  state_d = S_FETCH;
                  done_s  = 1'b1;
               end else begin
                  state_d = S_MEM;
               end
            end else begin
               if (mem_ready) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_MEM;
               end
            end
         end
         S_WB: begin
            rw_s    = 1'b1;
            state_d = S_FETCH;
            done_s  = 1'b1;
            if (is_addu_s || is_subu_s) begin
               rdst_s = 2'd1;
               wd_s   = 2'd0;
            end else if (is_lw_s) begin
               rdst_s = 2'd0;
               wd_s   = 2'd1;
            end else if (is_jal_s) begin
               rdst_s = 2'd2;
               wd_s   = 2'd2;
               pcw_s  = 1'b1;
               npc_s  = 2'd2;
            end else begin
               rdst_s = 2'd0;
               wd_s   = 2'd0;
            end
         end
         S_HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_FETCH;
`endif
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // State register and retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_FETCH;
         instr_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (done_s) begin
            instr_cnt_q <= instr_cnt_q + CNT_W'(1);
         end else begin
            instr_cnt_q <= instr_cnt_q;
         end
      end
   end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   // Sticky trap flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_q <= 1'b0;
      end else if (trap_s) begin
         illegal_q <= 1'b1;
      end else begin
         illegal_q <= illegal_q;
      end
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   // Write enables and the retire pulse are suppressed while reset is held
   assign PCWrite    = pcw_s  & ~reset;
   assign IRWrite    = irw_s  & ~reset;
   assign RegWrite   = rw_s   & ~reset;
   assign MemWrite   = mw_s   & ~reset;
   assign instr_done = done_s & ~reset;

   assign state      = state_q;
   assign ALUOp      = aluop_s;
   assign ALUSrcB    = srcb_s;
   assign EXTOp      = ext_s;
   assign RegDst     = rdst_s;
   assign WDSel      = wd_s;
   assign NPCOp      = npc_s;
   assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. The reference model works per
// instruction: it expands each instruction into its list of stages (with the
// requested number of memory wait cycles) and derives each stage's expected
// control word from the instruction semantics. A narrow counter (CW bits) makes
// the retired-count wrap reachable.
module tb_mc_controller;

   localparam int CW = 4;

   localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_NOP = 3, K_ORI = 4, K_LUI = 5;
   localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_JAL = 9, K_BADR = 10, K_BADOP = 11;
   localparam int K_3F = 12;

   localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3;
   localparam logic [2:0] ST_W = 3'd4, ST_H = 3'd5;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw, irw, rw, mw;
      logic [3:0] aluop;
      logic       srcb, ext;
      logic [1:0] rdst, wd, npc;
      logic       done;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, zero, mem_ready;
   logic [5:0]    opcode, funct;
   logic [2:0]    state;
   logic          PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcB, EXTOp, instr_done, illegal;
   logic [3:0]    ALUOp;
   logic [1:0]    RegDst, WDSel, NPCOp;
   logic [CW-1:0] instr_cnt;

   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] cnt_m;
   logic          ill_m;

   mc_controller #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .state(state), .PCWrite(PCWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
      .EXTOp(EXTOp), .RegDst(RegDst), .WDSel(WDSel), .NPCOp(NPCOp),
      .instr_done(instr_done), .instr_cnt(instr_cnt), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [19:0] obs_v;
   assign obs_v = {state, PCWrite, IRWrite, RegWrite, MemWrite, ALUOp, ALUSrcB, EXTOp,
                   RegDst, WDSel, NPCOp, instr_done};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Encoding of each instruction kind; unused fields are randomised
   task automatic code_of(input int k, output logic [5:0] op, output logic [5:0] fn);
      op = 6'h00;
      fn = 6'($urandom);
      case (k)
         K_ADDU:  fn = 6'h21;
         K_SUBU:  fn = 6'h23;
         K_JR:    fn = 6'h08;
         K_NOP:   fn = 6'h00;
         K_ORI:   op = 6'h0D;
         K_LUI:   op = 6'h0F;
         K_LW:    op = 6'h23;
         K_SW:    op = 6'h2B;
         K_BEQ:   op = 6'h04;
         K_JAL:   op = 6'h03;
         K_BADR:  begin
            while (fn == 6'h21 || fn == 6'h23 || fn == 6'h08 || fn == 6'h00) fn = 6'($urandom);
         end
         K_BADOP: begin
            op = 6'($urandom);
            while (op == 6'h00 || op == 6'h0D || op == 6'h0F || op == 6'h23 ||
                   op == 6'h2B || op == 6'h04 || op == 6'h03) op = 6'($urandom);
         end
         default: op = 6'h3F;
      endcase
   endtask

   // Expected control word for one stage of one instruction
   function automatic exp_t expect_of(input int k, input logic [2:0] st, input logic z,
                                      input logic last);
      exp_t e;
      e = '0;
      e.st = st;
      e.done = last;
      case (st)
         ST_F: begin e.pcw = 1'b1; e.irw = 1'b1; end
         ST_E: begin
            case (k)
               K_SUBU: e.aluop = 4'd1;
               K_BEQ:  begin e.aluop = 4'd1; e.pcw = z; e.npc = 2'd1; end
               K_ORI:  begin e.aluop = 4'd2; e.srcb = 1'b1; end
               K_LUI:  begin e.aluop = 4'd3; e.srcb = 1'b1; end
               K_LW, K_SW: begin e.srcb = 1'b1; e.ext = 1'b1; end
               K_JR:   begin e.pcw = 1'b1; e.npc = 2'd3; end
               default: e.aluop = 4'd0;
            endcase
         end
         ST_M: begin e.srcb = 1'b1; e.ext = 1'b1; e.mw = (k == K_SW); end
         ST_W: begin
            e.rw = 1'b1;
            if (k == K_ADDU || k == K_SUBU) e.rdst = 2'd1;
            if (k == K_LW) e.wd = 2'd1;
            if (k == K_JAL) begin e.rdst = 2'd2; e.wd = 2'd2; e.pcw = 1'b1; e.npc = 2'd2; end
         end
         default: e.done = last;
      endcase
      return e;
   endfunction

   // Compare one cycle at the falling edge, then advance past the next rising edge
   task automatic check_cycle(input exp_t e, input string tag);
      @(negedge clk);
      checks++;
      assert (obs_v === e) else begin
         errors++;
         $error("FAIL %s ctl observed=%h expected=%h", tag, obs_v, e);
      end
      checks++;
      assert (instr_cnt === cnt_m) else begin
         errors++;
         $error("FAIL %s instr_cnt observed=%0d expected=%0d", tag, instr_cnt, cnt_m);
      end
      checks++;
      assert (illegal === ill_m) else begin
         errors++;
         $error("FAIL %s illegal observed=%b expected=%b", tag, illegal, ill_m);
      end
      @(posedge clk);
      #1;
      if (e.done) cnt_m = cnt_m + 1'b1;
   endtask

   // Run one instruction; zmode 0/1 forces zero, 2 randomises it; rst_at aborts at that cycle
   task automatic run_instr(input int k, input int w, input int zmode, input int rst_at,
                            input string tag);
      logic [5:0] op, fn;
      logic [2:0] seq[$];
      logic       z;
      exp_t       e;
      int         mi;
      code_of(k, op, fn);
      seq = {ST_F, ST_D};
      case (k)
         K_ADDU, K_SUBU, K_ORI, K_LUI: begin seq.push_back(ST_E); seq.push_back(ST_W); end
         K_BEQ, K_JR: seq.push_back(ST_E);
         K_JAL: seq.push_back(ST_W);
         K_LW, K_SW: begin
            seq.push_back(ST_E);
            for (int j = 0; j <= w; j++) seq.push_back(ST_M);
            if (k == K_LW) seq.push_back(ST_W);
         end
         default: mi = 0;
      endcase
      mi = 0;
      for (int i = 0; i < seq.size(); i++) begin
         if (seq[i] == ST_F) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
         end else begin
            opcode = op;
            funct  = fn;
         end
         z = (zmode == 2) ? 1'($urandom) : (zmode == 1);
         zero = z;
         if (seq[i] == ST_M) begin
            mem_ready = (mi >= w);
            mi++;
         end else begin
            mem_ready = 1'($urandom);
         end
         e = expect_of(k, seq[i], z, i == seq.size() - 1);
         if (i == rst_at) begin
            reset = 1'b1;
            e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.done = 1'b0;
            check_cycle(e, {tag, "_rst"});
            reset = 1'b0;
            cnt_m = '0;
            ill_m = 1'b0;
            return;
         end
         check_cycle(e, tag);
      end
   endtask

   initial begin
      exp_t e;
      int   k;
      reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
      cnt_m = '0; ill_m = 1'b0;

      // Two reset cycles: state FETCH, every enable and the done pulse held low
      @(posedge clk);
      #1;
      e = '0;
      check_cycle(e, "reset");
      reset = 1'b0;

      run_instr(K_ADDU, 0, 2, -1, "addu");
      run_instr(K_LW,   3, 2, -1, "lw_wait3");
      run_instr(K_BEQ,  0, 1, -1, "beq_z1");
      run_instr(K_BEQ,  0, 0, -1, "beq_z0");
      run_instr(K_JAL,  0, 2, -1, "jal");
      run_instr(K_JR,   0, 2, -1, "jr");
      run_instr(K_SUBU, 0, 2, -1, "subu");
      run_instr(K_ORI,  0, 2, -1, "ori");
      run_instr(K_LUI,  0, 2, -1, "lui");
      run_instr(K_SW,   2, 2, -1, "sw_wait2");
      run_instr(K_NOP,  0, 2, -1, "nop");
      run_instr(K_LW,   0, 2, -1, "lw_fast");
      // Reset in the second MEM cycle of a stalled sw
      run_instr(K_SW,   5, 2,  4, "sw_abort");
      run_instr(K_ADDU, 0, 2, -1, "after_abort");

      for (int n = 0; n < 80; n++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         k = $urandom_range(0, 9);
`else
         k = $urandom_range(0, 11);
`endif
         run_instr(k, $urandom_range(0, 3), 2, ($urandom_range(0, 19) == 0) ? 3 : -1, "rand");
      end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      // Opcode 3Fh traps: DECODE without retirement, then HALT with sticky illegal
      opcode = 6'($urandom); mem_ready = 1'b1;
      check_cycle(expect_of(K_3F, ST_F, 1'b0, 1'b0), "trap_f");
      opcode = 6'h3F;
      check_cycle(expect_of(K_3F, ST_D, 1'b0, 1'b0), "trap_d");
      ill_m = 1'b1;
      for (int h = 0; h < 4; h++) begin
         mem_ready = 1'($urandom);
         zero = 1'($urandom);
         check_cycle(expect_of(K_3F, ST_H, 1'b0, 1'b0), "halt");
      end
      reset = 1'b1;
      check_cycle(expect_of(K_3F, ST_H, 1'b0, 1'b0), "halt_rst");
      reset = 1'b0;
      cnt_m = '0;
      ill_m = 1'b0;
      run_instr(K_ADDU, 0, 2, -1, "after_halt");
`else
      run_instr(K_3F, 0, 2, -1, "op3f_nop");
      run_instr(K_ADDU, 0, 2, -1, "after_op3f");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
